// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared constants and the light-state encoding for the traffic phase sequencer
// and the blocks that decode its phase output.
package traffic_pkg;

  localparam int SEC_W = 8;

  typedef enum logic [2:0] {
    S_RED       = 3'd0,
    S_RED_YEL   = 3'd1,
    S_GREEN     = 3'd2,
    S_YEL       = 3'd3,
    S_NIGHT_ON  = 3'd4,
    S_NIGHT_OFF = 3'd5
  } state_t;

endpackage

// File: rtl/traffic_phase_sequencer_tick_gen.sv
// Clock-enable divider: one-cycle tick every DIV cycles of clk_50MHz while en is high.
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk_50MHz,
  input  logic res,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50MHz) begin
    if (res) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Masked during reset so a reset landing on the last count never leaks a tick.
  assign tick = en & ~res & (cnt == LAST);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Light phase FSM with per-phase timer, pedestrian green shortening and
// blinking-yellow night mode, all advanced by the tick clock-enable.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_HZ  = 1,
  parameter int T_RED    = 10,
  parameter int T_RY     = 2,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int PED_CUT  = 2
) (
  input  logic             clk_50MHz,
  input  logic             res,
  input  logic             en,
  input  logic             ped_req,
  input  logic             night,
  output logic             red,
  output logic             yellow,
  output logic             green,
  output logic             ped_walk,
  output logic [2:0]       phase,
  output logic [SEC_W-1:0] sec_left,
  output logic             tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam logic [SEC_W-1:0] CUT = SEC_W'(PED_CUT);

  state_t           state, state_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic             ped_pending, ped_nxt;
  logic             entering_clear;

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk_50MHz (clk_50MHz),
    .res       (res),
    .en        (en),
    .tick      (tick)
  );

  function automatic logic [SEC_W-1:0] phase_load(input state_t s);
    case (s)
      S_RED:     phase_load = SEC_W'(T_RED - 1);
      S_RED_YEL: phase_load = SEC_W'(T_RY - 1);
      S_GREEN:   phase_load = SEC_W'(T_GREEN - 1);
      S_YEL:     phase_load = SEC_W'(T_YELLOW - 1);
      default:   phase_load = '0;
    endcase
  endfunction

  always_ff @(posedge clk_50MHz) begin
    if (res) begin
      state       <= S_RED;
      sec_left    <= SEC_W'(T_RED - 1);
      ped_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      sec_left    <= sec_nxt;
      ped_pending <= ped_nxt;
    end
  end

  // Night is only looked at when RED or NIGHT_OFF expires, never mid-cycle.
  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_left;
    if (tick) begin
      if (sec_left == '0) begin
        case (state)
          S_RED:       state_nxt = night ? S_NIGHT_ON : S_RED_YEL;
          S_RED_YEL:   state_nxt = S_GREEN;
          S_GREEN:     state_nxt = S_YEL;
          S_YEL:       state_nxt = S_RED;
          S_NIGHT_ON:  state_nxt = S_NIGHT_OFF;
          S_NIGHT_OFF: state_nxt = night ? S_NIGHT_ON : S_RED;
          default:     state_nxt = S_RED;
        endcase
        sec_nxt = phase_load(state_nxt);
      end else if ((state == S_GREEN) && ped_pending && (sec_left > CUT)) begin
        sec_nxt = CUT;
      end else begin
        sec_nxt = sec_left - SEC_W'(1);
      end
    end
  end

  // Serving the crossing clears the request, even one arriving on that same edge.
  always_comb begin
    entering_clear = (state_nxt != state) &&
                     ((state_nxt == S_RED) || (state_nxt == S_NIGHT_ON));
    ped_nxt = ped_pending;
    if (en && ped_req) begin
      ped_nxt = 1'b1;
    end
    if (entering_clear) begin
      ped_nxt = 1'b0;
    end
  end

  always_comb begin
    red      = 1'b0;
    yellow   = 1'b0;
    green    = 1'b0;
    ped_walk = 1'b0;
    case (state)
      S_RED: begin
        red      = 1'b1;
        ped_walk = 1'b1;
      end
      S_RED_YEL: begin
        red    = 1'b1;
        yellow = 1'b1;
      end
      S_GREEN:    green  = 1'b1;
      S_YEL:      yellow = 1'b1;
      S_NIGHT_ON: yellow = 1'b1;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer with DIV=10 and short phase lengths.
module tb_traffic_phase_sequencer;

  logic       clk_50MHz;
  logic       res;
  logic       en;
  logic       ped_req;
  logic       night;
  logic       red, yellow, green, ped_walk, tick;
  logic [2:0] phase;
  logic [7:0] sec_left;
  logic [3:0] lamps;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign lamps = {red, yellow, green, ped_walk};

  traffic_phase_sequencer #(
    .CLK_HZ   (10),
    .TICK_HZ  (1),
    .T_RED    (4),
    .T_RY     (1),
    .T_GREEN  (5),
    .T_YELLOW (2),
    .PED_CUT  (1)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .res       (res),
    .en        (en),
    .ped_req   (ped_req),
    .night     (night),
    .red       (red),
    .yellow    (yellow),
    .green     (green),
    .ped_walk  (ped_walk),
    .phase     (phase),
    .sec_left  (sec_left),
    .tick      (tick)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, run did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // {red, yellow, green, ped_walk} expected for each phase encoding
  function automatic logic [3:0] exp_lamps(input int p);
    case (p)
      0:       exp_lamps = 4'b1001;
      1:       exp_lamps = 4'b1100;
      2:       exp_lamps = 4'b0010;
      3:       exp_lamps = 4'b0100;
      4:       exp_lamps = 4'b0100;
      default: exp_lamps = 4'b0000;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  task automatic run_to(input int t);
    step(t - cyc);
    cyc = t;
  endtask

  task automatic do_reset();
    night   = 1'b0;
    ped_req = 1'b0;
    en      = 1'b1;
    res     = 1'b1;
    step(1);
    res = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    res = 1'b1; en = 1'b1; ped_req = 1'b0; night = 1'b0;
    step(3);
    checks++;
    if (lamps !== 4'b1001 || phase !== 3'd0 || sec_left !== 8'd3 || tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: lamps=%b phase=%0d sec_left=%0d tick=%b, expected lamps=1001 phase=0 sec_left=3 tick=0",
               lamps, phase, sec_left, tick);
    end
    checks++;
    if (dut.ped_pending !== 1'b0 || dut.u_tick_gen.cnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_internal: ped_pending=%b cnt=%0d, expected 0 and 0",
               dut.ped_pending, dut.u_tick_gen.cnt);
    end
  endtask

  task automatic test_free_run();
    int cc, ep, es;
    logic et;
    do_reset();
    for (int c = 1; c <= 240; c++) begin
      step(1);
      cc = c % 120;
      if (cc < 40) begin
        ep = 0; es = 3 - cc / 10;
      end else if (cc < 50) begin
        ep = 1; es = 0;
      end else if (cc < 100) begin
        ep = 2; es = 4 - (cc - 50) / 10;
      end else begin
        ep = 3; es = 1 - (cc - 100) / 10;
      end
      et = ((c % 10) == 9);
      checks++;
      if (phase !== ep[2:0] || lamps !== exp_lamps(ep) || sec_left !== es[7:0] || tick !== et) begin
        errors++;
        $display("[TB] FAIL free_run c=%0d: phase=%0d lamps=%b sec_left=%0d tick=%b, expected phase=%0d lamps=%b sec_left=%0d tick=%b",
                 c, phase, lamps, sec_left, tick, ep, exp_lamps(ep), es, et);
      end
    end
  endtask

  task automatic test_ped_green();
    do_reset();
    run_to(62);
    ped_req = 1'b1;
    run_to(63);
    ped_req = 1'b0;
    checks++;
    if (dut.ped_pending !== 1'b1 || sec_left !== 8'd3) begin
      errors++;
      $display("[TB] FAIL ped_register: ped_pending=%b sec_left=%0d, expected 1 and 3", dut.ped_pending, sec_left);
    end
    run_to(70);
    checks++;
    if (phase !== 3'd2 || sec_left !== 8'd1) begin
      errors++;
      $display("[TB] FAIL ped_cut: phase=%0d sec_left=%0d, expected phase=2 sec_left=1", phase, sec_left);
    end
    run_to(89);
    checks++;
    if (phase !== 3'd2 || sec_left !== 8'd0) begin
      errors++;
      $display("[TB] FAIL ped_green_tail: phase=%0d sec_left=%0d, expected phase=2 sec_left=0", phase, sec_left);
    end
    run_to(90);
    checks++;
    if (phase !== 3'd3 || lamps !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL ped_green_end: phase=%0d lamps=%b, expected phase=3 lamps=0100", phase, lamps);
    end
    run_to(109);
    checks++;
    if (dut.ped_pending !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ped_hold_until_red: ped_pending=%b, expected 1", dut.ped_pending);
    end
    run_to(110);
    checks++;
    if (dut.ped_pending !== 1'b0 || lamps !== 4'b1001 || phase !== 3'd0) begin
      errors++;
      $display("[TB] FAIL ped_clear_in_red: ped_pending=%b lamps=%b phase=%0d, expected 0 1001 0",
               dut.ped_pending, lamps, phase);
    end
  endtask

  task automatic test_late_req();
    do_reset();
    run_to(82);
    ped_req = 1'b1;
    run_to(83);
    ped_req = 1'b0;
    checks++;
    if (dut.ped_pending !== 1'b1 || sec_left !== 8'd1) begin
      errors++;
      $display("[TB] FAIL late_register: ped_pending=%b sec_left=%0d, expected 1 and 1", dut.ped_pending, sec_left);
    end
    run_to(90);
    checks++;
    if (phase !== 3'd2 || sec_left !== 8'd0) begin
      errors++;
      $display("[TB] FAIL late_no_cut: phase=%0d sec_left=%0d, expected phase=2 sec_left=0", phase, sec_left);
    end
    run_to(99);
    checks++;
    if (phase !== 3'd2) begin
      errors++;
      $display("[TB] FAIL late_green_len: phase=%0d, expected 2", phase);
    end
    run_to(119);
    ped_req = 1'b1;
    run_to(120);
    ped_req = 1'b0;
    checks++;
    if (phase !== 3'd0 || dut.ped_pending !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_wins: phase=%0d ped_pending=%b, expected phase=0 ped_pending=0", phase, dut.ped_pending);
    end
    run_to(121);
    checks++;
    if (dut.ped_pending !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_stays: ped_pending=%b, expected 0", dut.ped_pending);
    end
  endtask

  task automatic test_night();
    do_reset();
    run_to(70);
    night = 1'b1;
    run_to(100);
    checks++;
    if (phase !== 3'd3) begin
      errors++;
      $display("[TB] FAIL night_no_interrupt: phase=%0d, expected 3", phase);
    end
    run_to(159);
    checks++;
    if (phase !== 3'd0 || sec_left !== 8'd0) begin
      errors++;
      $display("[TB] FAIL night_red_complete: phase=%0d sec_left=%0d, expected 0 0", phase, sec_left);
    end
    run_to(160);
    checks++;
    if (phase !== 3'd4 || lamps !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL night_on: phase=%0d lamps=%b, expected 4 0100", phase, lamps);
    end
    run_to(170);
    checks++;
    if (phase !== 3'd5 || lamps !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL night_off: phase=%0d lamps=%b, expected 5 0000", phase, lamps);
    end
    run_to(180);
    checks++;
    if (phase !== 3'd4 || lamps !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL night_toggle: phase=%0d lamps=%b, expected 4 0100", phase, lamps);
    end
    run_to(205);
    night = 1'b0;
    run_to(219);
    checks++;
    if (phase !== 3'd5) begin
      errors++;
      $display("[TB] FAIL night_last_off: phase=%0d, expected 5", phase);
    end
    run_to(220);
    checks++;
    if (phase !== 3'd0 || sec_left !== 8'd3 || lamps !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL night_exit: phase=%0d sec_left=%0d lamps=%b, expected 0 3 1001", phase, sec_left, lamps);
    end
  endtask

  task automatic test_en_freeze();
    do_reset();
    run_to(63);
    en = 1'b0;
    for (int c = 64; c <= 100; c++) begin
      run_to(c);
      checks++;
      if (tick !== 1'b0 || sec_left !== 8'd3 || phase !== 3'd2 || dut.u_tick_gen.cnt !== 4'd3) begin
        errors++;
        $display("[TB] FAIL freeze c=%0d: tick=%b sec_left=%0d phase=%0d cnt=%0d, expected 0 3 2 3",
                 c, tick, sec_left, phase, dut.u_tick_gen.cnt);
      end
    end
    en = 1'b1;
    run_to(106);
    checks++;
    if (tick !== 1'b1 || sec_left !== 8'd3) begin
      errors++;
      $display("[TB] FAIL freeze_resume_tick: tick=%b sec_left=%0d, expected 1 3", tick, sec_left);
    end
    run_to(136);
    checks++;
    if (phase !== 3'd2 || sec_left !== 8'd0) begin
      errors++;
      $display("[TB] FAIL freeze_green_tail: phase=%0d sec_left=%0d, expected 2 0", phase, sec_left);
    end
    run_to(137);
    checks++;
    if (phase !== 3'd3 || sec_left !== 8'd1) begin
      errors++;
      $display("[TB] FAIL freeze_green_end: phase=%0d sec_left=%0d, expected 3 1", phase, sec_left);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_to(105);
    res = 1'b1;
    step(1);
    res = 1'b0;
    cyc = 0;
    checks++;
    if (lamps !== 4'b1001 || phase !== 3'd0 || sec_left !== 8'd3 || tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: lamps=%b phase=%0d sec_left=%0d tick=%b, expected 1001 0 3 0",
               lamps, phase, sec_left, tick);
    end
    run_to(8);
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_early_tick: tick=%b, expected 0", tick);
    end
    run_to(9);
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_first_tick: tick=%b, expected 1", tick);
    end
    run_to(10);
    checks++;
    if (sec_left !== 8'd2 || phase !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_after_tick: sec_left=%0d phase=%0d, expected 2 0", sec_left, phase);
    end
  endtask

  initial begin
    res = 1'b1; en = 1'b1; ped_req = 1'b0; night = 1'b0;
    test_reset();
    test_free_run();
    test_ped_green();
    test_late_req();
    test_night();
    test_en_freeze();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
